reload_counter_param: RTL and testbench

Parametrised self-reloading counter, the successor to the fixed 4-bit up-only reloading counter. Width is a parameter, and the counter adds count direction, a programmable terminal value, a count enable, one-shot mode, and status and terminal-count outputs. It is used as a programmable tick/period generator in downstream blocks. Reset defaults reproduce the old behaviour: count up from 0 to all-ones, then reload.

---
 rtl/reload_counter_pkg.sv | 13 +
 rtl/reload_counter_param.sv | 104 ++++++++++
 tb/tb_reload_counter_param.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/reload_counter_pkg.sv
// Shared types and reset defaults for the parametrised reloading counter.
package reload_counter_pkg;

    typedef enum logic {ST_RUN, ST_HALT} rc_state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} rc_dir_t;

    // Reset defaults: reload from zero and terminate at all-ones, which
    // reproduces the legacy up-only counter. The limit bit is replicated
    // to the counter width by the user.
    localparam int unsigned RC_DEF_RELOAD    = 0;
    localparam logic        RC_DEF_LIMIT_BIT = 1'b1;

endpackage

// File: rtl/reload_counter_param.sv
// Parametrised self-reloading counter: up/down, programmable terminal value,
// count enable, auto-reload or one-shot, registered tc/busy outputs.
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_RUN  | counting (holds while en_i is low)
//   ST_HALT | one-shot finished; waits for load_i or reset
module reload_counter_param
    import reload_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             dir_i,
    input  logic             oneshot_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             busy_o
);

    rc_state_t        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    rc_dir_t          dir_q, dir_d;
    logic             os_q, os_d;
    logic             tc_q, tc_d;

    // Next-state: load beats counting; terminal compare happens before the step,
    // so an unreachable limit simply wraps modulo 2^WIDTH until it is hit.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rld_d   = rld_q;
        lim_d   = lim_q;
        dir_d   = dir_q;
        os_d    = os_q;
        tc_d    = 1'b0;
        if (load_i) begin
            count_d = load_val_i;
            rld_d   = load_val_i;
            lim_d   = limit_i;
            dir_d   = rc_dir_t'(dir_i);
            os_d    = oneshot_i;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (en_i) begin
                        if (count_q == lim_q) begin
                            tc_d = 1'b1;
                            if (os_q) begin
                                state_d = ST_HALT;
                            end else begin
                                count_d = rld_q;
                            end
                        end else if (dir_q == DIR_UP) begin
                            count_d = count_q + WIDTH'(1);
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and configuration registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            count_q <= '0;
            rld_q   <= WIDTH'(RC_DEF_RELOAD);
            lim_q   <= {WIDTH{RC_DEF_LIMIT_BIT}};
            dir_q   <= DIR_UP;
            os_q    <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rld_q   <= rld_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            os_q    <= os_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign busy_o  = (state_q == ST_RUN);

endmodule

// File: tb/tb_reload_counter_param.sv
// Self-checking bench for reload_counter_param (WIDTH = 4): directed scenarios
// followed by a randomized phase, all compared against a behavioural model.
module tb_reload_counter_param;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         reset;
    logic         load_i;
    logic [W-1:0] load_val_i;
    logic [W-1:0] limit_i;
    logic         dir_i;
    logic         oneshot_i;
    logic         en_i;
    logic [W-1:0] count_o;
    logic         tc_o;
    logic         busy_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model state (plain integers).
    int m_cnt, m_rld, m_lim, m_down, m_os, m_done, m_tc;

    // Period tracking of observed tc pulses.
    int cyc        = 0;
    int last_tc    = -1;
    int exp_period = 0;

    reload_counter_param #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .limit_i    (limit_i),
        .dir_i      (dir_i),
        .oneshot_i  (oneshot_i),
        .en_i       (en_i),
        .count_o    (count_o),
        .tc_o       (tc_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int period_of(input int rld, input int lim, input int down);
        int d;
        d = down ? (rld - lim) : (lim - rld);
        return ((d % M) + M) % M + 1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs at negedge, update model at posedge, check #1 later.
    task automatic step(input logic rst, input logic ld, input int lv, input int lim,
                        input logic dn, input logic os, input logic en);
        @(negedge clk);
        reset = rst; load_i = ld; load_val_i = W'(lv); limit_i = W'(lim);
        dir_i = dn; oneshot_i = os; en_i = en;
        @(posedge clk);
        cyc++;
        m_tc = 0;
        if (rst) begin
            m_cnt = 0; m_rld = 0; m_lim = M - 1; m_down = 0; m_os = 0; m_done = 0;
        end else if (ld) begin
            m_cnt = lv % M; m_rld = lv % M; m_lim = lim % M; m_down = dn; m_os = os; m_done = 0;
        end else if (!m_done && en) begin
            if (m_cnt == m_lim) begin
                m_tc = 1;
                if (m_os) m_done = 1;
                else      m_cnt = m_rld;
            end else begin
                m_cnt = (m_cnt + (m_down ? M - 1 : 1)) % M;
            end
        end
        #1;
        chk("count", int'(count_o), m_cnt);
        chk("tc",    int'(tc_o),    m_tc);
        chk("busy",  int'(busy_o),  m_done ? 0 : 1);
        if (rst || ld) last_tc = -1;
        if (tc_o === 1'b1) begin
            if (last_tc >= 0 && exp_period > 0) chk("period", cyc - last_tc, exp_period);
            last_tc = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_load(input int lv, input int lim, input logic dn, input logic os);
        step(0, 1, lv, lim, dn, os, 1);
    endtask

    initial begin
        int found;
        int held_cnt;
        reset = 1'b1; load_i = 1'b0; load_val_i = '0; limit_i = '0;
        dir_i = 1'b0; oneshot_i = 1'b0; en_i = 1'b0;

        // 1: reset defaults, then free run 0..F with period 16.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        exp_period = period_of(0, M - 1, 0);
        run(40);

        // 2: up 6..F auto, period 10.
        exp_period = period_of(6, 15, 0);
        do_load(6, 15, 0, 0);
        run(30);

        // 3: down 9..2 auto, period 8, then a 3-cycle enable gap.
        exp_period = period_of(9, 2, 1);
        do_load(9, 2, 1, 0);
        run(20);
        exp_period = 0;
        held_cnt = m_cnt;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("freeze", int'(count_o), held_cnt);
        run(10);

        // 4: one-shot 3..5, then halt ignores enable, reload 0 resumes.
        do_load(3, 5, 0, 1);
        run(6);
        chk("halt_busy", int'(busy_o), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, (i % 2) == 0);
        chk("halt_hold", int'(count_o), 5);
        do_load(0, 15, 0, 0);
        chk("reload_busy", int'(busy_o), 1);
        run(3);

        // 5: wrap-through limit E->1, period 4, load A while count is 1.
        exp_period = period_of(14, 1, 0);
        do_load(14, 1, 0, 0);
        run(9);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_cnt == 1) found = 1;
            else run(1);
        end
        chk("wait_cnt1", found, 1);
        do_load(10, 1, 0, 0);
        chk("load_over_tc", int'(tc_o), 0);
        run(4);

        // 6: reset mid-count in down mode, defaults restored.
        exp_period = 0;
        do_load(9, 2, 1, 0);
        run(2);
        chk("pre_reset_cnt", int'(count_o), 7);
        step(1, 0, 0, 0, 0, 0, 1);
        exp_period = period_of(0, M - 1, 0);
        run(35);

        // Randomized phase.
        exp_period = 0;
        for (int i = 0; i < 600; i++) begin
            logic r, l;
            r = ($urandom_range(0, 63) == 0);
            l = ($urandom_range(0, 9) == 0);
            step(r, l, $urandom_range(0, M - 1), $urandom_range(0, M - 1),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
